cdc_level_event_queue: RTL and testbench

Receive-side stage directly downstream of the two-flop clock_a→clock_b synchronizer. It consumes the synchronized level in the clock_b domain and glitch-filters it. Each accepted rising or falling transition is converted into an event record in a small FIFO, read out through a valid/ready handshake. It also keeps a saturating event count and a sticky overflow flag for software/debug.

---
 rtl/cdc_level_event_queue.sv | 108 ++++++++++
 tb/tb_cdc_level_event_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_level_event_queue.sv
// cdc_level_event_queue
// Receive-side stage behind the clock_a -> clock_b level synchronizer. It
// glitch-filters the synchronized level and queues each accepted edge as a
// one-bit event record (1 = rise, 0 = fall) behind a valid/ready interface.
// It also keeps a saturating event count and a sticky overflow flag.
module cdc_level_event_queue #(
  parameter int FILTER_CYCLES = 3,
  parameter int DEPTH         = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clock_b,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             evt_ready,
  input  logic             clr_overflow,
  output logic             level,
  output logic             evt_valid,
  output logic             evt_rise,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow
);

  localparam int SW = $clog2(FILTER_CYCLES + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [SW-1:0] STAB_LAST = SW'(FILTER_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [SW-1:0] stab_inc(input logic [SW-1:0] v);
    stab_inc = v + SW'(1);
  endfunction

  logic [SW-1:0] stab_cnt_p0;
  logic          toggle_p0;
  logic          new_level_p0;

  logic [AW:0]   wr_ptr_p1;
  logic [AW:0]   rd_ptr_p1;
  logic          mem_p1 [DEPTH];
  logic          empty_p1;
  logic          full_p1;
  logic          pop_p1;
  logic          push_ok_p1;
  logic          drop_p1;

  // ---- stage p0: glitch filter on the synchronized level ----
  // The last of FILTER_CYCLES consecutive differing samples flips level.
  assign toggle_p0    = (data_in != level) && (stab_cnt_p0 == STAB_LAST);
  assign new_level_p0 = ~level;

  always_ff @(posedge clock_b or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt_p0 <= '0;
      level       <= 1'b0;
    end else if (data_in == level) begin
      stab_cnt_p0 <= '0;
    end else if (stab_cnt_p0 == STAB_LAST) begin
      stab_cnt_p0 <= '0;
      level       <= new_level_p0;
    end else begin
      stab_cnt_p0 <= stab_inc(stab_cnt_p0);
    end
  end

  // ---- stage p1: event FIFO, counters and overflow flag ----
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_p1   = (wr_ptr_p1 == rd_ptr_p1);
  assign full_p1    = (wr_ptr_p1[AW] != rd_ptr_p1[AW]) &&
                      (wr_ptr_p1[AW-1:0] == rd_ptr_p1[AW-1:0]);
  assign evt_valid  = ~empty_p1;
  assign pop_p1     = evt_valid && evt_ready;
  // A pop in the same cycle frees the slot the full-FIFO push needs.
  assign push_ok_p1 = toggle_p0 && (!full_p1 || pop_p1);
  assign drop_p1    = toggle_p0 && full_p1 && !pop_p1;

  // Payload storage holds only data, so it is left out of reset; the head
  // read is masked by evt_valid so the output is 0 whenever the queue is empty.
  assign evt_rise = evt_valid & mem_p1[rd_ptr_p1[AW-1:0]];

  always_ff @(posedge clock_b) begin
    if (push_ok_p1) mem_p1[wr_ptr_p1[AW-1:0]] <= new_level_p0;
  end

  always_ff @(posedge clock_b or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
    end else begin
      if (push_ok_p1) wr_ptr_p1 <= wr_ptr_p1 + (AW+1)'(1);
      if (pop_p1)     rd_ptr_p1 <= rd_ptr_p1 + (AW+1)'(1);
    end
  end

  // Every generated event counts, stored or dropped; a drop outranks a clear.
  always_ff @(posedge clock_b or negedge rst_n) begin
    if (!rst_n) begin
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (toggle_p0) evt_count <= sat_inc(evt_count);
      if (drop_p1)           overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdc_level_event_queue.sv
module tb_cdc_level_event_queue;

  localparam int FC    = 3;
  localparam int DEPTH = 4;

  logic       clock_b;
  logic       rst_n;
  logic       data_in;
  logic       evt_ready;
  logic       clr_overflow;
  logic       level, evt_valid, evt_rise, overflow;
  logic [7:0] evt_count;
  logic       level_s, evt_valid_s, evt_rise_s, overflow_s;
  logic [1:0] evt_count_s;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: filter history window, event queue, counters
  bit m_hist[$];
  bit m_level;
  bit m_q[$];
  int m_cnt;
  bit m_ovf;

  cdc_level_event_queue #(.FILTER_CYCLES(FC), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clock_b(clock_b), .rst_n(rst_n), .data_in(data_in), .evt_ready(evt_ready),
    .clr_overflow(clr_overflow), .level(level), .evt_valid(evt_valid),
    .evt_rise(evt_rise), .evt_count(evt_count), .overflow(overflow));

  cdc_level_event_queue #(.FILTER_CYCLES(FC), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clock_b(clock_b), .rst_n(rst_n), .data_in(data_in), .evt_ready(evt_ready),
    .clr_overflow(clr_overflow), .level(level_s), .evt_valid(evt_valid_s),
    .evt_rise(evt_rise_s), .evt_count(evt_count_s), .overflow(overflow_s));

  initial clock_b = 1'b0;
  always #5 clock_b = ~clock_b;

  task automatic model_reset();
    m_hist.delete();
    m_q.delete();
    m_level = 1'b0;
    m_cnt   = 0;
    m_ovf   = 1'b0;
  endtask

  // Level flips once the last FC samples all differ from it; each flip is an
  // event that is queued if there is room after this cycle's pop.
  task automatic model_update(input bit d, input bit r, input bit c);
    bit toggle;
    bit drop;
    m_hist.push_back(d);
    if (m_hist.size() > FC) void'(m_hist.pop_front());
    toggle = (m_hist.size() == FC);
    foreach (m_hist[i]) if (m_hist[i] == m_level) toggle = 1'b0;
    if (r && m_q.size() > 0) void'(m_q.pop_front());
    drop = 1'b0;
    if (toggle) begin
      m_level = ~m_level;
      m_cnt++;
      if (m_q.size() < DEPTH) m_q.push_back(m_level);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  function automatic int exp_cnt(input int w);
    int lim;
    lim = (1 << w) - 1;
    return (m_cnt > lim) ? lim : m_cnt;
  endfunction

  task automatic step(input bit d, input bit r, input bit c);
    data_in = d; evt_ready = r; clr_overflow = c;
    @(posedge clock_b);
    model_update(d, r, c);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_in = 1'b0; evt_ready = 1'b0; clr_overflow = 1'b0;
    #12;
    n_cmp++; if (level !== 1'b0) begin n_err++; $display("FAIL reset_level got=%b exp=0", level); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
    n_cmp++; if (evt_rise !== 1'b0) begin n_err++; $display("FAIL reset_rise got=%b exp=0", evt_rise); end
    n_cmp++; if (evt_count !== 8'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", evt_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_cmp++; if (evt_count_s !== 2'd0) begin n_err++; $display("FAIL reset_count_sat got=%0d exp=0", evt_count_s); end
    model_reset();
    @(negedge clock_b);
    rst_n = 1'b1;
  endtask

  task automatic test_filter();
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
    n_cmp++; if (level !== 1'b0) begin n_err++; $display("FAIL glitch_level got=%b exp=0", level); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid got=%b exp=0", evt_valid); end
    n_cmp++; if (evt_count !== 8'd0) begin n_err++; $display("FAIL glitch_count got=%0d exp=0", evt_count); end
    step(1, 0, 0); step(1, 0, 0);
    n_cmp++; if (level !== 1'b0) begin n_err++; $display("FAIL early_level got=%b exp=0", level); end
    step(1, 0, 0);
    n_cmp++; if (level !== 1'b1) begin n_err++; $display("FAIL rise_level got=%b exp=1", level); end
    n_cmp++; if (evt_valid !== 1'b1) begin n_err++; $display("FAIL rise_valid got=%b exp=1", evt_valid); end
    n_cmp++; if (evt_rise !== 1'b1) begin n_err++; $display("FAIL rise_payload got=%b exp=1", evt_rise); end
    n_cmp++; if (evt_count !== 8'd1) begin n_err++; $display("FAIL rise_count got=%0d exp=1", evt_count); end
    n_cmp++; if (evt_count_s !== 2'd1) begin n_err++; $display("FAIL rise_count_sat got=%0d exp=1", evt_count_s); end
  endtask

  task automatic test_handshake();
    // head is the rise from the filter test; queue a fall behind it
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0);
      n_cmp++; if (evt_valid !== 1'b1 || evt_rise !== 1'b1) begin
        n_err++; $display("FAIL hold_head cyc=%0d got=%b/%b exp=1/1", i, evt_valid, evt_rise);
      end
    end
    n_cmp++; if (level !== 1'b0) begin n_err++; $display("FAIL fall_level got=%b exp=0", level); end
    step(0, 1, 0);
    n_cmp++; if (evt_valid !== 1'b1 || evt_rise !== 1'b0) begin
      n_err++; $display("FAIL pop1 got=%b/%b exp=1/0", evt_valid, evt_rise);
    end
    step(0, 1, 0);
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL pop2_valid got=%b exp=0", evt_valid); end
    step(0, 1, 0);
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL ready_empty got=%b exp=0", evt_valid); end
  endtask

  task automatic test_overflow();
    int  cnt0;
    bit  order[4];
    order = '{1'b1, 1'b0, 1'b1, 1'b0};
    cnt0 = m_cnt;
    for (int t = 0; t < 5; t++)
      for (int k = 0; k < FC; k++) step((t % 2) == 0, 0, 0);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    n_cmp++; if (evt_count !== 8'(cnt0 + 5)) begin n_err++; $display("FAIL ovf_count got=%0d exp=%0d", evt_count, cnt0 + 5); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (evt_valid !== 1'b1 || evt_rise !== order[i]) begin
        n_err++; $display("FAIL ovf_drain%0d got=%b/%b exp=1/%b", i, evt_valid, evt_rise, order[i]);
      end
      step(1, 1, 0);
    end
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got=%b exp=0", evt_valid); end
  endtask

  task automatic test_simultaneous();
    bit order[4];
    order = '{1'b1, 1'b0, 1'b1, 1'b0};
    step(1, 0, 1);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf got=%b exp=0", overflow); end
    for (int t = 0; t < 4; t++)
      for (int k = 0; k < FC; k++) step((t % 2) == 1, 0, 0);
    // push of a fall lands on the same edge as a pop of the full queue
    step(0, 0, 0); step(0, 0, 0); step(0, 1, 0);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL simul_ovf got=%b exp=0", overflow); end
    n_cmp++; if (evt_valid !== 1'b1 || evt_rise !== 1'b1) begin
      n_err++; $display("FAIL simul_head got=%b/%b exp=1/1", evt_valid, evt_rise);
    end
    // dropped push coincides with clr_overflow: set wins
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 1);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL set_dominant got=%b exp=1", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (evt_valid !== 1'b1 || evt_rise !== order[i]) begin
        n_err++; $display("FAIL simul_drain%0d got=%b/%b exp=1/%b", i, evt_valid, evt_rise, order[i]);
      end
      step(1, 1, 0);
    end
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL simul_empty got=%b exp=0", evt_valid); end
    step(1, 0, 1);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_after got=%b exp=0", overflow); end
  endtask

  task automatic test_saturation();
    int cnt0;
    cnt0 = m_cnt;
    for (int t = 0; t < 5; t++)
      for (int k = 0; k < FC; k++) step((t % 2) == 0 ? 1'b0 : 1'b1, 1, 0);
    n_cmp++; if (evt_count_s !== 2'd3) begin n_err++; $display("FAIL sat_hold got=%0d exp=3", evt_count_s); end
    n_cmp++; if (evt_count !== 8'(cnt0 + 5)) begin n_err++; $display("FAIL sat_wide got=%0d exp=%0d", evt_count, cnt0 + 5); end
    step(0, 1, 0);
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL sat_drained got=%b exp=0", evt_valid); end
  endtask

  task automatic test_random();
    bit d;
    int run;
    int rdy_pct;
    d = 1'b0; run = 0; rdy_pct = 50;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (run == 0) begin
        d = $urandom_range(0, 1);
        run = $urandom_range(1, 6);
      end
      run--;
      if (cyc % 100 == 0) rdy_pct = $urandom_range(0, 100);
      step(d, $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 15) == 0);
      n_cmp++; if (level !== m_level || evt_valid !== (m_q.size() > 0) || overflow !== m_ovf) begin
        n_err++; $display("FAIL rnd_ctrl cyc=%0d got=%b%b%b exp=%b%b%b", cyc, level, evt_valid, overflow,
                          m_level, m_q.size() > 0, m_ovf);
      end
      if (m_q.size() > 0) begin
        n_cmp++; if (evt_rise !== m_q[0]) begin
          n_err++; $display("FAIL rnd_rise cyc=%0d got=%b exp=%b", cyc, evt_rise, m_q[0]);
        end
      end
      n_cmp++; if (evt_count !== 8'(exp_cnt(8)) || evt_count_s !== 2'(exp_cnt(2))) begin
        n_err++; $display("FAIL rnd_count cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, evt_count, evt_count_s,
                          exp_cnt(8), exp_cnt(2));
      end
      n_cmp++; if (level_s !== level || evt_valid_s !== evt_valid || evt_rise_s !== evt_rise || overflow_s !== overflow) begin
        n_err++; $display("FAIL rnd_sat_inst cyc=%0d got=%b%b%b%b exp=%b%b%b%b", cyc, level_s, evt_valid_s,
                          evt_rise_s, overflow_s, level, evt_valid, evt_rise, overflow);
      end
    end
  endtask

  task automatic test_async_reset();
    bit l0;
    for (int i = 0; i < 8; i++) step(m_level, 1, 0);
    l0 = m_level;
    for (int k = 0; k < FC; k++) step(~l0, 0, 0);
    for (int k = 0; k < FC; k++) step(l0, 0, 0);
    step(~l0, 0, 0);
    n_cmp++; if (evt_valid !== 1'b1) begin n_err++; $display("FAIL ar_queued got=%b exp=1", evt_valid); end
    #2;
    rst_n = 1'b0;
    data_in = 1'b1;
    #1;
    n_cmp++; if (level !== 1'b0 || evt_valid !== 1'b0 || evt_rise !== 1'b0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL ar_outputs got=%b%b%b%b exp=0000", level, evt_valid, evt_rise, overflow);
    end
    n_cmp++; if (evt_count !== 8'd0 || evt_count_s !== 2'd0) begin
      n_err++; $display("FAIL ar_count got=%0d/%0d exp=0/0", evt_count, evt_count_s);
    end
    model_reset();
    @(negedge clock_b);
    rst_n = 1'b1;
    for (int k = 0; k < FC - 1; k++) begin
      step(1, 0, 0);
      n_cmp++; if (level !== 1'b0 || evt_valid !== 1'b0) begin
        n_err++; $display("FAIL ar_early%0d got=%b/%b exp=0/0", k, level, evt_valid);
      end
    end
    step(1, 0, 0);
    n_cmp++; if (level !== 1'b1 || evt_valid !== 1'b1 || evt_rise !== 1'b1 || evt_count !== 8'd1) begin
      n_err++; $display("FAIL ar_rise got=%b%b%b/%0d exp=111/1", level, evt_valid, evt_rise, evt_count);
    end
  endtask

  initial begin
    test_reset();
    test_filter();
    test_handshake();
    test_overflow();
    test_simultaneous();
    test_saturation();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
